// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, word/state types and color-field helpers for the VGA write path.
// No logic of its own; imported by vga_cell_addr and vga_fb_writer.
package vga_pkg;

    localparam int PIXEL_W = 16;
    localparam int PIXEL_H = 16;
    localparam int COLS    = 640 / PIXEL_W;
    localparam int ROWS    = 480 / PIXEL_H;
    localparam int CELLS   = COLS * ROWS;

    typedef logic [15:0] fb_word_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_e;

    function automatic logic [3:0] fb_red(input fb_word_t w);
        return w[3:0];
    endfunction

    function automatic logic [3:0] fb_green(input fb_word_t w);
        return w[7:4];
    endfunction

    function automatic logic [3:0] fb_blue(input fb_word_t w);
        return w[11:8];
    endfunction

    function automatic fb_word_t fb_pack_rgb(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        return {4'h0, b, g, r};
    endfunction

endpackage

// File: rtl/vga_cell_addr.sv
// Cell coordinate to framebuffer word address, plus out-of-bounds flag.
// Purely combinational; the row scale assumes a 40-column grid (row*40 = row*32 + row*8).
module vga_cell_addr
    import vga_pkg::*;
#(
    parameter int COLS_P = COLS,
    parameter int ROWS_P = ROWS
) (
    input  logic [5:0]  col,
    input  logic [4:0]  row,
    input  logic [15:0] base,
    output logic [15:0] addr,
    output logic        oob
);

    localparam logic [5:0] COL_LIM = 6'(COLS_P);
    localparam logic [4:0] ROW_LIM = 5'(ROWS_P);

    assign addr = base + {6'b0, row, 5'b0} + {8'b0, row, 3'b0} + {10'b0, col};
    assign oob  = (col >= COL_LIM) || (row >= ROW_LIM);

endmodule

// File: rtl/vga_fb_writer.sv
// Framebuffer write port: cell writes registered to the RAM one cycle after handshake.
// Optional whole-screen clear engine enabled by the VGA_FB_CLEAR_EN macro.
module vga_fb_writer
    import vga_pkg::*;
#(
    parameter logic [15:0] WIDTH      = 16'd640,
    parameter logic [15:0] HEIGHT     = 16'd480,
    parameter logic [15:0] VGA_REGION = 16'h2000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_col,
    input  logic [4:0]  req_row,
    input  logic [15:0] req_data,
    input  logic        clr_start,
    input  logic [15:0] clr_data,
    output logic        busy,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data,
    output logic        mem_wren,
    output logic        err_oob
);

    localparam int COLS_P = int'(WIDTH) / PIXEL_W;
    localparam int ROWS_P = int'(HEIGHT) / PIXEL_H;

    logic [15:0] cell_addr;
    logic        cell_oob;
    logic        req_fire;

    fb_word_t mem_addr_q, mem_addr_d;
    fb_word_t mem_data_q, mem_data_d;
    logic     mem_wren_q, mem_wren_d;
    logic     err_oob_q,  err_oob_d;

    vga_cell_addr #(
        .COLS_P (COLS_P),
        .ROWS_P (ROWS_P)
    ) u_cell_addr (
        .col  (req_col),
        .row  (req_row),
        .base (VGA_REGION),
        .addr (cell_addr),
        .oob  (cell_oob)
    );

`ifdef VGA_FB_CLEAR_EN
    // cnt_q is the index of the next clear word; reaching CELLS means the last word is on the bus.
    localparam logic [10:0] CELLS_L = 11'(COLS_P * ROWS_P);

    fb_state_e   state_q, state_d;
    logic [10:0] cnt_q, cnt_d;
    fb_word_t    clr_data_q, clr_data_d;

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        err_oob_d  = 1'b0;
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_data_d = clr_data_q;
        req_ready  = (state_q == IDLE) && !clr_start;
        req_fire   = req_valid && req_ready;

        if (req_fire) begin
            err_oob_d = cell_oob;
            if (!cell_oob) begin
                mem_wren_d = 1'b1;
                mem_addr_d = cell_addr;
                mem_data_d = req_data;
            end
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    state_d    = CLEAR;
                    clr_data_d = clr_data;
                    mem_wren_d = 1'b1;
                    mem_addr_d = VGA_REGION;
                    mem_data_d = clr_data;
                    cnt_d      = 11'd1;
                end
            end
            CLEAR: begin
                if (cnt_q == CELLS_L) begin
                    state_d = IDLE;
                    cnt_d   = 11'd0;
                end else begin
                    mem_wren_d = 1'b1;
                    mem_addr_d = VGA_REGION + {5'b0, cnt_q};
                    mem_data_d = clr_data_q;
                    cnt_d      = cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 11'd0;
            clr_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_data_q <= clr_data_d;
        end
    end

    assign busy = (state_q == CLEAR) || mem_wren_q;
`else
    logic unused_clr;
    assign unused_clr = clr_start ^ (^clr_data);

    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wren_d = 1'b0;
        err_oob_d  = 1'b0;
        req_ready  = !reset;
        req_fire   = req_valid && req_ready;

        if (req_fire) begin
            err_oob_d = cell_oob;
            if (!cell_oob) begin
                mem_wren_d = 1'b1;
                mem_addr_d = cell_addr;
                mem_data_d = req_data;
            end
        end
    end

    assign busy = mem_wren_q;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wren_q <= 1'b0;
            err_oob_q  <= 1'b0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wren_q <= mem_wren_d;
            err_oob_q  <= err_oob_d;
        end
    end

    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wren = mem_wren_q;
    assign err_oob  = err_oob_q;

endmodule

// File: tb/tb_vga_fb_writer.sv
// Bench for vga_fb_writer: directed cases plus randomized writes against an address-arithmetic model.
// Clear-engine scenarios are built only when VGA_FB_CLEAR_EN is defined.
module tb_vga_fb_writer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_col = '0;
    logic [4:0]  req_row = '0;
    logic [15:0] req_data = '0;
    logic        clr_start = 1'b0;
    logic [15:0] clr_data = '0;
    logic        busy;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        err_oob;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_fb_writer dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_col   (req_col),
        .req_row   (req_row),
        .req_data  (req_data),
        .clr_start (clr_start),
        .clr_data  (clr_data),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_wren  (mem_wren),
        .err_oob   (err_oob)
    );

    // Reference: framebuffer is row-major, 40 words per row, based at 0x2000.
    function automatic logic [15:0] ref_addr(input int col, input int row);
        int a;
        a = 32'h2000 + row * 40 + col;
        return a[15:0];
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({mem_wren, err_oob, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got wren/oob/busy=%b want 000", {mem_wren, err_oob, busy});
        end
        checks++;
        if (mem_addr !== 16'h0000 || mem_data !== 16'h0000) begin
            errors++;
            $display("FAIL reset_bus got addr=%h data=%h want 0000 0000", mem_addr, mem_data);
        end
`ifndef VGA_FB_CLEAR_EN
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b want 0", req_ready);
        end
`endif
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready got %b want 1", req_ready);
        end
    endtask

    task automatic test_single();
        @(negedge clock);
        req_valid = 1'b1; req_col = 6'd0; req_row = 5'd0; req_data = 16'h0F00;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_ready got %b want 1", req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if ({mem_wren, err_oob, busy} !== 3'b101 || mem_addr !== 16'h2000 || mem_data !== 16'h0F00) begin
            errors++;
            $display("FAIL single_write got wren/oob/busy=%b addr=%h data=%h want 101 2000 0F00",
                     {mem_wren, err_oob, busy}, mem_addr, mem_data);
        end
        @(negedge clock);
        checks++;
        if ({mem_wren, busy} !== 2'b00) begin
            errors++;
            $display("FAIL single_idle got wren/busy=%b want 00", {mem_wren, busy});
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        req_valid = 1'b1; req_col = 6'd39; req_row = 5'd29; req_data = 16'hA5A5;
        @(negedge clock);
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h24AF || mem_data !== 16'hA5A5) begin
            errors++;
            $display("FAIL b2b_first got wren=%b addr=%h data=%h want 1 24AF A5A5", mem_wren, mem_addr, mem_data);
        end
        req_col = 6'd1; req_row = 5'd2; req_data = 16'h5A5A;
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h2051 || mem_data !== 16'h5A5A) begin
            errors++;
            $display("FAIL b2b_second got wren=%b addr=%h data=%h want 1 2051 5A5A", mem_wren, mem_addr, mem_data);
        end
        @(negedge clock);
        checks++;
        if (mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain got wren=%b want 0", mem_wren);
        end
    endtask

    task automatic test_oob();
        @(negedge clock);
        req_valid = 1'b1; req_col = 6'd40; req_row = 5'd0; req_data = 16'hFFFF;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL oob_ready got %b want 1", req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b0 || err_oob !== 1'b1) begin
            errors++;
            $display("FAIL oob_pulse got wren=%b oob=%b want 0 1", mem_wren, err_oob);
        end
        @(negedge clock);
        checks++;
        if (mem_wren !== 1'b0 || err_oob !== 1'b0) begin
            errors++;
            $display("FAIL oob_clear got wren=%b oob=%b want 0 0", mem_wren, err_oob);
        end
    endtask

    task automatic test_random();
        logic        exp_vld = 1'b0;
        logic        exp_oob = 1'b0;
        logic [15:0] exp_a = '0;
        logic [15:0] exp_d = '0;
        int          c;
        int          r;
        for (int i = 0; i < 301; i++) begin
            @(negedge clock);
            checks++;
            if (mem_wren !== (exp_vld && !exp_oob) || err_oob !== (exp_vld && exp_oob)
                || busy !== (exp_vld && !exp_oob)) begin
                errors++;
                $display("FAIL rand_ctrl[%0d] got wren/oob/busy=%b%b%b want %b%b%b", i, mem_wren, err_oob, busy,
                         exp_vld && !exp_oob, exp_vld && exp_oob, exp_vld && !exp_oob);
            end
            if (exp_vld && !exp_oob) begin
                checks++;
                if (mem_addr !== exp_a || mem_data !== exp_d) begin
                    errors++;
                    $display("FAIL rand_bus[%0d] got addr=%h data=%h want %h %h", i, mem_addr, mem_data, exp_a, exp_d);
                end
            end
            c = $urandom_range(45);
            r = $urandom_range(31);
            req_valid = (i < 300) && ($urandom_range(3) != 0);
            req_col   = 6'(c);
            req_row   = 5'(r);
            req_data  = 16'($urandom);
            #1;
            checks++;
            if (req_ready !== 1'b1) begin
                errors++;
                $display("FAIL rand_ready[%0d] got %b want 1", i, req_ready);
            end
            exp_vld = req_valid;
            exp_oob = (c >= 40) || (r >= 30);
            exp_a   = ref_addr(c, r);
            exp_d   = req_data;
        end
        req_valid = 1'b0;
    endtask

`ifdef VGA_FB_CLEAR_EN
    task automatic test_clear();
        int bad = 0;
        @(negedge clock);
        req_valid = 1'b1; req_col = 6'd3; req_row = 5'd1; req_data = 16'h0BEE;
        @(negedge clock);
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h202B || mem_data !== 16'h0BEE) begin
            errors++;
            $display("FAIL clr_prior_write got wren=%b addr=%h data=%h want 1 202B 0BEE", mem_wren, mem_addr, mem_data);
        end
        clr_start = 1'b1; clr_data = 16'h0123;
        req_col = 6'd5; req_row = 5'd5; req_data = 16'h7777;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL clr_collide_ready got %b want 0", req_ready);
        end
        for (int k = 0; k < 1200; k++) begin
            @(negedge clock);
            clr_start = (k == 100);
            clr_data  = (k == 100) ? 16'hDEAD : 16'h0000;
            #1;
            if (mem_wren !== 1'b1 || mem_addr !== ref_addr(k, 0) || mem_data !== 16'h0123
                || busy !== 1'b1 || req_ready !== 1'b0) begin
                if (bad < 5)
                    $display("FAIL clr_word[%0d] got wren=%b addr=%h data=%h busy=%b rdy=%b want 1 %h 0123 1 0",
                             k, mem_wren, mem_addr, mem_data, busy, req_ready, ref_addr(k, 0));
                bad++;
            end
        end
        clr_start = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL clr_sweep got %0d bad words want 0", bad);
        end
        @(negedge clock);
        #1;
        checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clr_end got wren=%b busy=%b rdy=%b want 0 0 1", mem_wren, busy, req_ready);
        end
        @(negedge clock);
        req_valid = 1'b0;
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h20CD || mem_data !== 16'h7777) begin
            errors++;
            $display("FAIL clr_held_req got wren=%b addr=%h data=%h want 1 20CD 7777", mem_wren, mem_addr, mem_data);
        end
        @(negedge clock);
    endtask

    task automatic test_clear_reset();
        int seen = 0;
        @(negedge clock);
        clr_start = 1'b1; clr_data = 16'h0456;
        @(negedge clock);
        clr_start = 1'b0;
        repeat (499) @(negedge clock);
        checks++;
        if (mem_wren !== 1'b1 || mem_addr !== 16'h21F3) begin
            errors++;
            $display("FAIL clrrst_progress got wren=%b addr=%h want 1 21F3", mem_wren, mem_addr);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL clrrst_abort got wren=%b busy=%b want 0 0", mem_wren, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (mem_wren !== 1'b0) seen++;
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (mem_wren !== 1'b0 || busy !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL clrrst_quiet got %0d active cycles want 0", seen);
        end
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL clrrst_ready got %b want 1", req_ready);
        end
    endtask
`else
    task automatic test_clr_ignored();
        @(negedge clock);
        clr_start = 1'b1; clr_data = 16'h0123;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL noclr_ready got %b want 1", req_ready);
        end
        @(negedge clock);
        clr_start = 1'b0;
        repeat (3) begin
            checks++;
            if (mem_wren !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL noclr_quiet got wren=%b busy=%b want 0 0", mem_wren, busy);
            end
            @(negedge clock);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_oob();
        test_random();
`ifdef VGA_FB_CLEAR_EN
        test_clear();
        test_clear_reset();
`else
        test_clr_ignored();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
